// File: rtl/video_vicii_palette_pkg.sv
// video_vicii_palette_pkg: colour type, built-in VIC-II palettes and write-FSM states
package video_vicii_palette_pkg;
  typedef logic [23:0] rgb24_t;
  typedef enum logic [1:0] {IDLE, WAIT_BLANK, COMMIT} wr_state_t;
  localparam rgb24_t PAL0 [16] = '{
    24'h000000, 24'hFFFFFF, 24'h68372B, 24'h70A4B2, 24'h6F3D86, 24'h588D43, 24'h352879, 24'hB8C76F,
    24'h6F4F25, 24'h433900, 24'h9A6759, 24'h444444, 24'h6C6C6C, 24'h9AD284, 24'h6C5EB5, 24'h959595};
  localparam rgb24_t PAL1 [16] = '{
    24'h000000, 24'hFFFFFF, 24'h813338, 24'h75CEC8, 24'h8E3C97, 24'h56AC4D, 24'h2E2C9B, 24'hEDF171,
    24'h8E5029, 24'h553800, 24'hC46C71, 24'h4A4A4A, 24'h7B7B7B, 24'hA9FF9F, 24'h706DEB, 24'hB2B2B2};
  localparam rgb24_t PAL2 [16] = '{
    24'h000000, 24'hFFFFFF, 24'h894036, 24'h7ABFC7, 24'h8A46AE, 24'h68A941, 24'h3E31A2, 24'hD0DC71,
    24'h905F25, 24'h5C4700, 24'hBB776D, 24'h555555, 24'h808080, 24'hACEA88, 24'h7C70DA, 24'hABABAB};
endpackage

// File: rtl/video_vicii_palette_palrom.sv
// video_vicii_palette_palrom: combinational lookup into the three built-in palettes
module video_vicii_palette_palrom
  import video_vicii_palette_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [3:0] index,
  output rgb24_t     rgb
);
  assign rgb = (sel == 2'd1) ? PAL1[index] : (sel == 2'd2) ? PAL2[index] : PAL0[index];
endmodule

// File: rtl/video_vicii_palette.sv
// video_vicii_palette: two-stage colour-index to RGB pipeline with a frame-synchronous
// palette select and a custom palette that is only rewritten during blanking.
module video_vicii_palette
  import video_vicii_palette_pkg::*;
#(
  parameter bit BLANK_BLACK = 1'b1,
  parameter int PIPE_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [3:0]  color,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hblank_i,
  input  logic        vblank_i,
  input  logic [1:0]  pal_sel,
  input  logic        pal_wr,
  input  logic [3:0]  pal_addr,
  input  logic [23:0] pal_data,
  output logic        pal_ack,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank
);
  if (PIPE_LAT != 2) begin : g_bad_lat
    $error("PIPE_LAT must be 2");
  end
  logic [3:0] s1_color;
  logic       s1_hs, s1_vs, s1_hb, s1_vb;
  logic [1:0] act_sel;
  rgb24_t     custom [16];
  rgb24_t     rom_rgb, look_rgb;
  wr_state_t  state, state_nx;
  logic       commit;
  video_vicii_palette_palrom u_rom (.sel(act_sel), .index(s1_color), .rgb(rom_rgb));
  // custom read sees the pre-commit value; a same-clk write lands after this edge
  assign look_rgb = (act_sel == 2'd3) ? custom[s1_color] : rom_rgb;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {s1_color, s1_hs, s1_vs, s1_hb, s1_vb} <= '0;
      act_sel <= 2'd0;
      {R, G, B} <= 24'h0;
      {hsync, vsync, hblank, vblank} <= 4'h0;
    end else if (ce_pix) begin
      {s1_color, s1_hs, s1_vs, s1_hb, s1_vb} <= {color, hsync_i, vsync_i, hblank_i, vblank_i};
      act_sel <= (vsync_i && !s1_vs) ? pal_sel : act_sel;
      {R, G, B} <= (BLANK_BLACK && (s1_hb || s1_vb)) ? 24'h0 : look_rgb;
      {hsync, vsync, hblank, vblank} <= {s1_hs, s1_vs, s1_hb, s1_vb};
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) custom <= PAL0;
    else if (commit) custom[pal_addr] <= pal_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    commit = 1'b0;
    case (state)
      IDLE:       state_nx = pal_wr ? WAIT_BLANK : IDLE;
      WAIT_BLANK: state_nx = !pal_wr ? IDLE : (hblank_i || vblank_i) ? COMMIT : WAIT_BLANK;
      COMMIT: begin
        state_nx = IDLE;
        commit = 1'b1;
      end
      default:    state_nx = IDLE;
    endcase
  end
  assign pal_ack = commit;
endmodule
